display_scan_ctrl: RTL

Time-multiplexing scheduler for the 4-digit common-anode seven-segment display. It sequences the digit anodes and inserts an anti-ghosting blank before each digit. It applies PWM brightness and presents the per-digit nibble to the segment decoder. It also arbitrates display ownership between the normal value source (encoder count) and a timed overlay requester (pushbutton press-type message) through a req/ack handshake.

---
 rtl/display_scan_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit seven-segment scan scheduler with
// anti-ghost blanking, PWM brightness and frame-timed overlay.
module display_scan_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int DIGIT_CYCLES   = 1024,
   parameter int BLANK_CYCLES   = 16,
   parameter int OVERLAY_FRAMES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [2:0]              brightness,
   input  logic                    ovl_req,
   input  logic [4*NUM_DIGITS-1:0] ovl_value,
   output logic                    ovl_ack,
   output logic                    ovl_active,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [3:0]              nibble,
   output logic                    frame_tick
);

   localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int FW = (OVERLAY_FRAMES > 1) ? $clog2(OVERLAY_FRAMES) : 1;
   localparam int STEP = (DIGIT_CYCLES - BLANK_CYCLES) / 8;

   localparam logic [CW-1:0] C_LAST = CW'(DIGIT_CYCLES - 1);
   localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);
   localparam logic [FW-1:0] F_LAST = FW'(OVERLAY_FRAMES - 1);

   logic [CW-1:0]           c, c_nxt;
   logic [DW-1:0]           d, d_nxt;
   logic [FW-1:0]           f, f_nxt;
   logic [4*NUM_DIGITS-1:0] s_reg, s_nxt;
   logic [4*NUM_DIGITS-1:0] o_reg, o_nxt;
   logic                    act_nxt;
   logic                    ack_nxt;
   logic                    boundary;
   logic [NUM_DIGITS-1:0]   anode_nxt;
   logic [3:0]              nib_nxt;
   int                      on_end;
   int                      c_pos;

   // Slot/cycle position counters and frame boundary detect
   always_comb begin
      boundary = (c == C_LAST) && (d == D_LAST);
      c_nxt    = c + CW'(1);
      d_nxt    = d;
      if (c == C_LAST) begin
         c_nxt = '0;
         d_nxt = (d == D_LAST) ? '0 : d + DW'(1);
      end
   end

   // Frame-boundary snapshot and overlay ownership arbitration
   always_comb begin
      s_nxt   = s_reg;
      o_nxt   = o_reg;
      f_nxt   = f;
      act_nxt = ovl_active;
      ack_nxt = 1'b0;
      if (boundary) begin
         s_nxt = digits_in;
         if (ovl_req) begin
            o_nxt   = ovl_value;
            f_nxt   = '0;
            act_nxt = 1'b1;
            ack_nxt = 1'b1;
         end else if (ovl_active) begin
            if (f == F_LAST) begin
               act_nxt = 1'b0;
               f_nxt   = '0;
            end else begin
               f_nxt = f + FW'(1);
            end
         end
      end
   end

   // Anode PWM window and nibble select for the upcoming cycle
   always_comb begin
      on_end    = BLANK_CYCLES + (int'(brightness) + 1) * STEP;
      c_pos     = int'(c_nxt);
      anode_nxt = '0;
      if (c_pos >= BLANK_CYCLES && c_pos < on_end && digit_en[d_nxt])
         anode_nxt[d_nxt] = 1'b1;
      nib_nxt = act_nxt ? o_nxt[4*d_nxt +: 4] : s_nxt[4*d_nxt +: 4];
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         c          <= C_LAST;
         d          <= D_LAST;
         f          <= '0;
         s_reg      <= '0;
         o_reg      <= '0;
         ovl_active <= 1'b0;
         ovl_ack    <= 1'b0;
         frame_tick <= 1'b0;
         anode      <= '0;
         nibble     <= '0;
      end else begin
         c          <= c_nxt;
         d          <= d_nxt;
         f          <= f_nxt;
         s_reg      <= s_nxt;
         o_reg      <= o_nxt;
         ovl_active <= act_nxt;
         ovl_ack    <= ack_nxt;
         frame_tick <= boundary;
         anode      <= anode_nxt;
         nibble     <= nib_nxt;
      end
   end

endmodule
